// File: rtl/store_lane_buffer_pkg.sv
// Shared store definitions: opcodes, size decode, big-endian lane masks and
// the splitter FSM state type used by store_lane_buffer.
package store_pkg;
  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SD = 6'b111111;

  typedef enum logic {ST_IDLE = 1'b0, ST_SPLIT = 1'b1} split_state_t;

  // Store size in bytes; 0 means the opcode is not a store on an nb-lane bus.
  function automatic logic [3:0] store_size(input logic [5:0] opcode, input int nb);
    logic [3:0] s;
    case (opcode)
      OP_SB:   s = 4'd1;
      OP_SH:   s = 4'd2;
      OP_SW:   s = 4'd4;
      OP_SD:   s = (nb == 8) ? 4'd8 : 4'd0;
      default: s = 4'd0;
    endcase
    return s;
  endfunction

  // Lanes o..o+s-1, clipped to the word; lane 0 lands on bit nb-1.
  function automatic logic [7:0] lane_mask(input int s, input int o, input int nb);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < nb && i >= o && i < o + s) m = m | (8'd1 << (nb - 1 - i));
    end
    return m;
  endfunction
endpackage

// File: rtl/store_lane_buffer_fifo.sv
// store_fifo: DEPTH-entry queue of memory beats {addr, wdata, we}; head fields
// read as zero while empty so the memory side idles at all-zero.
module store_fifo #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NB     = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_valid_i,
  output logic              push_ready_o,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic [NB-1:0]     push_we_i,
  output logic              pop_valid_o,
  input  logic              pop_ready_i,
  output logic [ADDR_W-1:0] pop_addr_o,
  output logic [DATA_W-1:0] pop_data_o,
  output logic [NB-1:0]     pop_we_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [NB-1:0]     we_mem   [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              full, empty, push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // Push is refused when full even if the head pops on the same edge.
  assign push  = push_valid_i && !full;
  assign pop   = !empty && pop_ready_i;

  assign push_ready_o = !full;
  assign pop_valid_o  = !empty;
  assign pop_addr_o   = empty ? '0 : addr_mem[rd_ptr_q];
  assign pop_data_o   = empty ? '0 : data_mem[rd_ptr_q];
  assign pop_we_o     = empty ? '0 : we_mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= push_addr_i;
      data_mem[wr_ptr_q] <= push_data_i;
      we_mem[wr_ptr_q]   <= push_we_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/store_lane_buffer.sv
// Store unit: decodes store opcodes into big-endian lane enables and data and
// queues beats in store_fifo. Define STORE_SPLIT_EN to split word-crossing stores.
module store_lane_buffer
  import store_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [5:0]          req_opcode_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_data_i,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_we_o,
  output logic                misalign_err_o,
  output logic                busy_o
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);

  logic [3:0]        size;
  logic [OW-1:0]     offs;
  int                s_i, o_i;
  logic              is_store, crossing, accept;
  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] val, b1_data;
  logic [NB-1:0]     b1_we;
  split_state_t      state_q;
  logic              push_valid, push_ready;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;
  logic [NB-1:0]     push_we;

  assign size      = store_size(req_opcode_i, NB);
  assign offs      = req_addr_i[OW-1:0];
  assign s_i       = int'(size);
  assign o_i       = int'(offs);
  assign is_store  = (size != 4'd0);
  assign crossing  = (o_i + s_i) > NB;
  assign word_addr = {req_addr_i[ADDR_W-1:OW], {OW{1'b0}}};

  // Beat 1 carries the most-significant bytes; a crossing store keeps only
  // what fits from lane o to the end of the word.
  always_comb begin
    val = req_data_i & ~({DATA_W{1'b1}} << (8 * s_i));
    if (crossing) b1_data = val >> (8 * (o_i + s_i - NB));
    else          b1_data = val << (8 * (NB - s_i - o_i));
    b1_we = NB'(lane_mask(s_i, o_i, NB));
  end

`ifdef STORE_SPLIT_EN
  split_state_t      state_d;
  logic [ADDR_W-1:0] b2_addr_q;
  logic [DATA_W-1:0] b2_data_q;
  logic [NB-1:0]     b2_we_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && is_store && crossing) state_d = ST_SPLIT;
      default:  if (push_ready) state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      b2_addr_q <= '0;
      b2_data_q <= '0;
      b2_we_q   <= '0;
    end else if (state_q == ST_IDLE && accept && is_store && crossing) begin
      b2_addr_q <= word_addr + ADDR_W'(NB);
      b2_data_q <= val << (8 * (2 * NB - o_i - s_i));
      b2_we_q   <= NB'(lane_mask(o_i + s_i - NB, 0, NB));
    end
  end

  assign misalign_err_o = 1'b0;
`else
  logic misaligned, err_d, err_q;

  assign state_q    = ST_IDLE;
  assign misaligned = is_store && ((offs & OW'(size - 4'd1)) != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign misalign_err_o = err_q;
`endif

  always_comb begin
    req_ready_o = 1'b0;
    accept      = 1'b0;
    push_valid  = 1'b0;
    push_addr   = word_addr;
    push_data   = b1_data;
    push_we     = b1_we;
`ifndef STORE_SPLIT_EN
    err_d       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        req_ready_o = push_ready;
        accept      = req_valid_i && push_ready;
`ifdef STORE_SPLIT_EN
        push_valid  = accept && is_store;
`else
        push_valid  = accept && is_store && !misaligned;
        err_d       = accept && is_store && misaligned;
`endif
      end
      default: begin
`ifdef STORE_SPLIT_EN
        push_valid = 1'b1;
        push_addr  = b2_addr_q;
        push_data  = b2_data_q;
        push_we    = b2_we_q;
`endif
      end
    endcase
  end

  store_fifo #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .NB    (NB),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_valid_i(push_valid),
    .push_ready_o(push_ready),
    .push_addr_i (push_addr),
    .push_data_i (push_data),
    .push_we_i   (push_we),
    .pop_valid_o (mem_valid_o),
    .pop_ready_i (mem_ready_i),
    .pop_addr_o  (mem_addr_o),
    .pop_data_o  (mem_wdata_o),
    .pop_we_o    (mem_we_o)
  );

  assign busy_o = mem_valid_o || (state_q == ST_SPLIT);
endmodule

// File: tb/tb_store_lane_buffer.sv
// Self-checking bench for store_lane_buffer (DATA_W=32, DEPTH=4); the byte-address
// reference model follows STORE_SPLIT_EN the same way the design does.
module tb_store_lane_buffer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;
  localparam int NB     = DATA_W / 8;
  localparam logic [5:0] SB = 6'b101000;
  localparam logic [5:0] SH = 6'b101001;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] SD = 6'b111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [5:0] req_opcode = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_data = '0;
  logic mem_valid, mem_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0] mem_we;
  logic misalign_err, busy;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  we;
  } beat_t;
  beat_t exp_q[$];
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  store_lane_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_opcode_i(req_opcode),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
    .misalign_err_o(misalign_err), .busy_o(busy)
  );

  function automatic int ref_size(input logic [5:0] op);
    if (op == SB) return 1;
    if (op == SH) return 2;
    if (op == SW) return 4;
    if (op == SD) return (DATA_W == 64) ? 8 : 0;
    return 0;
  endfunction

  // Reference: write each byte of the value to consecutive byte addresses in
  // big-endian memory, then group the touched bytes by word.
  task automatic model_store(input logic [5:0] op, input logic [31:0] a,
                             input logic [31:0] d, output bit err);
    int s, o, pos, w, l;
    beat_t b[2];
    bit used[2];
    logic [7:0] byt;
    err = 1'b0;
    s = ref_size(op);
    if (s == 0) return;
    o = int'(a % NB);
`ifndef STORE_SPLIT_EN
    if (o % s != 0) begin
      err = 1'b1;
      return;
    end
`endif
    for (int i = 0; i < 2; i++) begin
      b[i].addr = (a - (a % NB)) + 32'(i * NB);
      b[i].data = '0;
      b[i].we   = '0;
      used[i]   = 1'b0;
    end
    for (int k = 0; k < s; k++) begin
      pos = o + k;
      w = pos / NB;
      l = pos % NB;
      byt = 8'(d >> (8 * (s - 1 - k)));
      b[w].we[NB-1-l] = 1'b1;
      b[w].data[8*(NB-1-l) +: 8] = byt;
      used[w] = 1'b1;
    end
    for (int i = 0; i < 2; i++) if (used[i]) exp_q.push_back(b[i]);
  endtask

  task automatic rand_aligned(output logic [5:0] op, output logic [31:0] a, output logic [31:0] d);
    case ($urandom_range(0, 2))
      0:       op = SB;
      1:       op = SH;
      default: op = SW;
    endcase
    a = $urandom & 32'h00FF_FFFF;
    a = a & ~(32'(ref_size(op)) - 32'd1);
    d = $urandom;
  endtask

  // Presents one request from a negedge and returns on the negedge after it is accepted.
  task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_opcode = op; req_addr = a; req_data = d;
    #1;
    while (!req_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      compared++; mismatched++;
      $display("FAIL send_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, n);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic pop1();
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if ({mem_valid, mem_addr, mem_wdata, mem_we, misalign_err, busy, req_ready} !== {1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL reset_state: valid=%0b addr=%h wdata=%h we=%b err=%0b busy=%0b ready=%0b, required 0/0/0/0/0/0/1",
               mem_valid, mem_addr, mem_wdata, mem_we, misalign_err, busy, req_ready);
    end
    $display("txn reset released");
  endtask

  task automatic test_sb_lanes();
    logic [3:0]  we_tab [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [31:0] wd_tab [4] = '{32'hAB000000, 32'h00AB0000, 32'h0000AB00, 32'h000000AB};
    logic [31:0] d;
    mem_ready = 1'b0;
    for (int o = 0; o < 4; o++) begin
      d = $urandom;
      d[7:0] = 8'hAB;
      send(SB, 32'h40 + 32'(o), d);
      compared++;
      if ({mem_valid, mem_addr, mem_we, mem_wdata} !== {1'b1, 32'h40, we_tab[o], wd_tab[o]}) begin
        mismatched++;
        $display("FAIL sb_offset%0d: valid=%0b addr=%h we=%b wdata=%h, required 1 00000040 %b %h",
                 o, mem_valid, mem_addr, mem_we, mem_wdata, we_tab[o], wd_tab[o]);
      end
      $display("txn SB off=%0d we=%b wdata=%h", o, mem_we, mem_wdata);
      pop1();
    end
  endtask

  task automatic test_sh_sw();
    logic [31:0] d;
    d = {16'($urandom), 16'h1234};
    send(SH, 32'h102, d);
    compared++;
    if ({mem_valid, mem_addr, mem_we, mem_wdata} !== {1'b1, 32'h100, 4'b0011, 32'h00001234}) begin
      mismatched++;
      $display("FAIL sh_0x102: valid=%0b addr=%h we=%b wdata=%h, required 1 00000100 0011 00001234",
               mem_valid, mem_addr, mem_we, mem_wdata);
    end
    $display("txn SH addr=%h we=%b wdata=%h", mem_addr, mem_we, mem_wdata);
    pop1();
    d = $urandom;
    send(SW, 32'h200, d);
    compared++;
    if ({mem_valid, mem_addr, mem_we, mem_wdata} !== {1'b1, 32'h200, 4'b1111, d}) begin
      mismatched++;
      $display("FAIL sw_0x200: valid=%0b addr=%h we=%b wdata=%h, required 1 00000200 1111 %h",
               mem_valid, mem_addr, mem_we, mem_wdata, d);
    end
    $display("txn SW addr=%h we=%b wdata=%h", mem_addr, mem_we, mem_wdata);
    pop1();
  endtask

  task automatic test_misaligned();
    mem_ready = 1'b0;
    send(SW, 32'h3, 32'hAABBCCDD);
`ifdef STORE_SPLIT_EN
    compared++;
    if ({mem_valid, mem_addr, mem_we, mem_wdata, misalign_err} !== {1'b1, 32'h0, 4'b0001, 32'h000000AA, 1'b0}) begin
      mismatched++;
      $display("FAIL split_beat1: valid=%0b addr=%h we=%b wdata=%h err=%0b, required 1 00000000 0001 000000aa 0",
               mem_valid, mem_addr, mem_we, mem_wdata, misalign_err);
    end
    $display("txn split beat1 addr=%h we=%b wdata=%h", mem_addr, mem_we, mem_wdata);
    pop1();
    compared++;
    if ({mem_valid, mem_addr, mem_we, mem_wdata} !== {1'b1, 32'h4, 4'b1110, 32'hBBCCDD00}) begin
      mismatched++;
      $display("FAIL split_beat2: valid=%0b addr=%h we=%b wdata=%h, required 1 00000004 1110 bbccdd00",
               mem_valid, mem_addr, mem_we, mem_wdata);
    end
    $display("txn split beat2 addr=%h we=%b wdata=%h", mem_addr, mem_we, mem_wdata);
    pop1();
    send(SH, 32'h21, 32'h00001234);
    compared++;
    if ({mem_valid, mem_addr, mem_we, mem_wdata} !== {1'b1, 32'h20, 4'b0110, 32'h00123400}) begin
      mismatched++;
      $display("FAIL sh_misaligned_inword: valid=%0b addr=%h we=%b wdata=%h, required 1 00000020 0110 00123400",
               mem_valid, mem_addr, mem_we, mem_wdata);
    end
    $display("txn SH misaligned addr=%h we=%b wdata=%h", mem_addr, mem_we, mem_wdata);
    pop1();
`else
    compared++;
    if ({misalign_err, mem_valid, busy} !== 3'b100) begin
      mismatched++;
      $display("FAIL misalign_pulse: err=%0b valid=%0b busy=%0b, required 1 0 0", misalign_err, mem_valid, busy);
    end
    @(negedge clk);
    compared++;
    if ({misalign_err, mem_valid} !== 2'b00) begin
      mismatched++;
      $display("FAIL misalign_one_cycle: err=%0b valid=%0b, required 0 0", misalign_err, mem_valid);
    end
    $display("txn SW misaligned dropped");
    send(SH, 32'h21, 32'h00001234);
    compared++;
    if ({misalign_err, mem_valid} !== 2'b10) begin
      mismatched++;
      $display("FAIL misalign_sh: err=%0b valid=%0b, required 1 0", misalign_err, mem_valid);
    end
    $display("txn SH misaligned dropped");
    @(negedge clk);
`endif
  endtask

  task automatic test_nonstore();
    logic [5:0] op;
    for (int i = 0; i < 12; i++) begin
      op = 6'($urandom);
      if (ref_size(op) != 0) op = 6'b000000;
      if (i == 0) op = SD;
      req_valid = 1'b1; req_opcode = op; req_addr = $urandom; req_data = $urandom;
      #1;
      compared++;
      if (req_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL nonstore_ready: op=%b ready=%0b, required 1", op, req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      compared++;
      if ({mem_valid, mem_we, misalign_err, busy} !== 7'b0) begin
        mismatched++;
        $display("FAIL nonstore_dropped: op=%b valid=%0b we=%b err=%0b busy=%0b, required all 0",
                 op, mem_valid, mem_we, misalign_err, busy);
      end
      $display("txn nonstore op=%b dropped", op);
    end
  endtask

  task automatic test_fifo_full();
    logic [5:0] op;
    logic [31:0] a, d;
    bit e;
    exp_q.delete();
    mem_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rand_aligned(op, a, d);
      send(op, a, d);
      model_store(op, a, d, e);
    end
    #1;
    compared++;
    if ({req_ready, busy, mem_valid} !== 3'b011) begin
      mismatched++;
      $display("FAIL fifo_full: ready=%0b busy=%0b valid=%0b, required 0 1 1", req_ready, busy, mem_valid);
    end
    mem_ready = 1'b1;
    #1;
    compared++;
    if (req_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL full_push_blocked_on_pop: ready=%0b, required 0", req_ready);
    end
    for (int i = 0; i < DEPTH; i++) begin
      compared++;
      if ({mem_valid, mem_addr, mem_we, mem_wdata} !== {1'b1, exp_q[0].addr, exp_q[0].we, exp_q[0].data}) begin
        mismatched++;
        $display("FAIL fifo_order%0d: valid=%0b addr=%h we=%b wdata=%h, required 1 %h %b %h",
                 i, mem_valid, mem_addr, mem_we, mem_wdata, exp_q[0].addr, exp_q[0].we, exp_q[0].data);
      end
      $display("txn fifo pop%0d addr=%h we=%b wdata=%h", i, mem_addr, mem_we, mem_wdata);
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    mem_ready = 1'b0;
    compared++;
    if ({mem_valid, busy} !== 2'b00) begin
      mismatched++;
      $display("FAIL fifo_drained: valid=%0b busy=%0b, required 0 0", mem_valid, busy);
    end
  endtask

  task automatic test_random();
    bit err_exp, accepted, e;
    int s, cyc;
    exp_q.delete();
    err_exp = 1'b0;
    accepted = 1'b0;
    for (cyc = 0; cyc < 900; cyc++) begin
      @(negedge clk);
      if (accepted) begin
        req_valid = 1'b0;
        accepted = 1'b0;
      end
      if (cyc >= 600 && !req_valid && exp_q.size() == 0) break;
      if (cyc < 600 && !req_valid && $urandom_range(0, 9) < 6) begin
        case ($urandom_range(0, 5))
          0:       req_opcode = SB;
          1:       req_opcode = SH;
          2:       req_opcode = SW;
          3:       req_opcode = SD;
          default: req_opcode = 6'($urandom);
        endcase
        req_addr = $urandom & 32'h00FF_FFFF;
        s = ref_size(req_opcode);
        if (s > 0 && $urandom_range(0, 1) == 0) req_addr = req_addr & ~(32'(s) - 32'd1);
        req_data = $urandom;
        req_valid = 1'b1;
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      #1;
      compared++;
      if (misalign_err !== err_exp) begin
        mismatched++;
        $display("FAIL rand_err cyc=%0d: err=%0b, required %0b", cyc, misalign_err, err_exp);
      end
      err_exp = 1'b0;
      compared++;
      if (busy !== (exp_q.size() != 0)) begin
        mismatched++;
        $display("FAIL rand_busy cyc=%0d: busy=%0b, required %0b", cyc, busy, exp_q.size() != 0);
      end
      compared++;
      if (mem_valid) begin
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL rand_unexpected cyc=%0d: addr=%h we=%b wdata=%h, required no beat", cyc, mem_addr, mem_we, mem_wdata);
        end else if ({mem_addr, mem_we, mem_wdata} !== {exp_q[0].addr, exp_q[0].we, exp_q[0].data}) begin
          mismatched++;
          $display("FAIL rand_beat cyc=%0d: addr=%h we=%b wdata=%h, required %h %b %h",
                   cyc, mem_addr, mem_we, mem_wdata, exp_q[0].addr, exp_q[0].we, exp_q[0].data);
        end
        if (mem_ready && exp_q.size() != 0) begin
          $display("txn rand pop addr=%h we=%b wdata=%h", mem_addr, mem_we, mem_wdata);
          void'(exp_q.pop_front());
        end
      end else if (mem_we !== 4'b0 || exp_q.size() != 0) begin
        mismatched++;
        $display("FAIL rand_idle cyc=%0d: we=%b pending=%0d, required 0000 and 0", cyc, mem_we, exp_q.size());
      end
      if (req_valid && req_ready) begin
        model_store(req_opcode, req_addr, req_data, e);
        err_exp = e;
        accepted = 1'b1;
      end
    end
    compared++;
    if (exp_q.size() != 0 || req_valid) begin
      mismatched++;
      $display("FAIL rand_drain: pending=%0d req_valid=%0b, required 0 0", exp_q.size(), req_valid);
    end
    req_valid = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_split();
    logic [5:0] op;
    logic [31:0] a, d;
    bit seen;
    mem_ready = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      rand_aligned(op, a, d);
      send(op, a, d);
    end
    send(SW, 32'h107, 32'h11223344);
    #1;
    compared++;
    if ({busy, mem_valid} !== 2'b11) begin
      mismatched++;
      $display("FAIL pre_reset_busy: busy=%0b valid=%0b, required 1 1", busy, mem_valid);
    end
`ifdef STORE_SPLIT_EN
    compared++;
    if (req_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL split_stalled_ready: ready=%0b, required 0", req_ready);
    end
`endif
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({mem_valid, busy, mem_we, misalign_err} !== 7'b0) begin
      mismatched++;
      $display("FAIL async_reset: valid=%0b busy=%0b we=%b err=%0b, required all 0", mem_valid, busy, mem_we, misalign_err);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (mem_valid || busy) seen = 1'b1;
    end
    compared++;
    if (seen !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_discards_beat2: activity seen=%0b, required 0", seen);
    end
    $display("txn reset during pending stores");
    mem_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sb_lanes();
    test_sh_sw();
    test_misaligned();
    test_nonstore();
    test_fifo_full();
    test_random();
    test_reset_split();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
